// File: rtl/spu_fetch_unit.sv
// rtl/spu_fetch_unit.sv - SPU instruction fetch unit: line requests, line FIFO, multi-slot issue, redirect; SPU_FETCH_PREFETCH_EN enables multi-line prefetch
module spu_fetch_unit #(
    parameter int LINE_WORDS  = 16,
    parameter int ISSUE_WIDTH = 2,
    parameter int PC_WIDTH    = 8,
    parameter int BUF_LINES   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      read_enable,
    output logic [PC_WIDTH-1:0]       pc,
    input  logic                      line_valid,
    input  logic [LINE_WORDS*32-1:0]  line_in,
    input  logic                      stall,
    input  logic                      branch_taken,
    input  logic [PC_WIDTH-1:0]       branch_target,
    output logic [ISSUE_WIDTH-1:0]    ins_valid,
    output logic [ISSUE_WIDTH*32-1:0] ins_out,
    output logic [PC_WIDTH-1:0]       ins_pc
);
    localparam int OW = $clog2(LINE_WORDS);
    localparam int PW = $clog2(BUF_LINES);
    localparam int CW = $clog2(BUF_LINES + 1);
    localparam logic [PC_WIDTH-1:0] LINE_STEP  = PC_WIDTH'(LINE_WORDS);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(LINE_WORDS - 1);

    logic [LINE_WORDS*32-1:0] fifo_data [BUF_LINES];
    logic [PC_WIDTH-1:0]      fifo_base [BUF_LINES];
    logic [PW-1:0]            wr_ptr, rd_ptr;
    logic [CW-1:0]            count;
    logic [OW-1:0]            head_off;
    logic [PC_WIDTH-1:0]      fetch_pc;
    logic                     in_flight, squash;

    logic [LINE_WORDS*32-1:0]  head_line;
    logic [PC_WIDTH-1:0]       head_base;
    logic [ISSUE_WIDTH-1:0]    slot_valid;
    logic [ISSUE_WIDTH*32-1:0] slot_data;
    int                        issue_cnt, next_off;
    logic                      fifo_empty, can_req, req, push, pop;

    always_comb begin
        head_line  = fifo_data[rd_ptr];
        head_base  = fifo_base[rd_ptr];
        slot_valid = '0;
        slot_data  = '0;
        issue_cnt  = 0;
        // A group never crosses into the next line; trailing slots go invalid instead.
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (int'(head_off) + i < LINE_WORDS) begin
                slot_valid[ISSUE_WIDTH-1-i] = 1'b1;
                slot_data[(ISSUE_WIDTH-1-i)*32 +: 32] =
                    head_line[(LINE_WORDS-1-int'(head_off)-i)*32 +: 32];
                issue_cnt = issue_cnt + 1;
            end
        end
        next_off   = int'(head_off) + issue_cnt;
        fifo_empty = (count == '0);
`ifdef SPU_FETCH_PREFETCH_EN
        can_req = !in_flight && (int'(count) + int'(in_flight) < BUF_LINES);
`else
        can_req = !in_flight && fifo_empty;
`endif
        req  = !reset && !branch_taken && can_req;
        push = !reset && !branch_taken && line_valid && !squash;
        pop  = !reset && !branch_taken && !stall && !fifo_empty && (next_off >= LINE_WORDS);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= line_in;
            fifo_base[wr_ptr] <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            read_enable <= 1'b0;
            pc          <= '0;
            ins_valid   <= '0;
            ins_out     <= '0;
            ins_pc      <= '0;
            fetch_pc    <= '0;
            head_off    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            in_flight   <= 1'b0;
            squash      <= 1'b0;
        end else begin
            read_enable <= req;
            if (req) begin
                pc       <= fetch_pc;
                fetch_pc <= fetch_pc + LINE_STEP;
            end
            if (req) begin
                in_flight <= 1'b1;
            end else if (line_valid) begin
                in_flight <= 1'b0;
            end

            if (branch_taken) begin
                // A line returning on this very edge is already dropped, so it needs no squash.
                squash    <= in_flight && !line_valid;
                fetch_pc  <= branch_target & ALIGN_MASK;
                head_off  <= branch_target[OW-1:0];
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                ins_valid <= '0;
            end else begin
                if (line_valid && squash) begin
                    squash <= 1'b0;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: ;
                endcase
                if (!stall) begin
                    if (!fifo_empty) begin
                        ins_valid <= slot_valid;
                        ins_out   <= slot_data;
                        ins_pc    <= head_base | PC_WIDTH'(head_off);
                        head_off  <= pop ? '0 : OW'(next_off);
                    end else begin
                        ins_valid <= '0;
                    end
                end
            end
        end
    end
endmodule
